booth_seq_divider: RTL and testbench

- Sequential signed two's-complement divider. It is the inverse-operation companion to the shift/add Booth multiplier datapath.
- Computes quotient and remainder of dividend / divisor using restoring division on magnitudes, one bit per clock, followed by a sign-correction cycle.
- Sits beside the multiplier in the arithmetic unit and shares its word-width parameter and start/done style of control.

---
 rtl/booth_seq_divider.sv | 100 ++++++++++
 tb/tb_booth_seq_divider.sv | 124 ++++++++++++
 2 files changed

// File: rtl/booth_seq_divider.sv
// booth_seq_divider: signed restoring divider, one quotient bit per clock; define DIV_EARLY_ZERO_EN for the zero-dividend shortcut
module booth_seq_divider #(
  parameter int l_word = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [l_word-1:0] dividend,
  input  logic [l_word-1:0] divisor,
  output logic              ready,
  output logic              done,
  output logic [l_word-1:0] quotient,
  output logic [l_word-1:0] remainder,
  output logic              div_by_zero,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [l_word-1:0] pr, dm, dvm, min_val;
  logic q_neg, r_neg, ovf_p;
  logic [l_word:0] sh, trial;
  assign min_val = {1'b1, {(l_word-1){1'b0}}};
  // dm holds the dividend magnitude and fills with quotient bits as it shifts out
  always_comb begin
    sh = {pr, dm[l_word-1]};
    trial = sh - {1'b0, dvm};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pr <= '0;
      dm <= '0;
      dvm <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      ovf_p <= 1'b0;
      ready <= 1'b1;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ready && start) begin
        q_neg <= dividend[l_word-1] ^ divisor[l_word-1];
        r_neg <= dividend[l_word-1];
        dm <= dividend[l_word-1] ? -dividend : dividend;
        dvm <= divisor[l_word-1] ? -divisor : divisor;
        ovf_p <= (dividend == min_val) && (divisor == '1);
        pr <= '0;
        cnt <= 6'(l_word);
        if (divisor == '0) begin
          state <= DONE;
          done <= 1'b1;
          quotient <= '1;
          remainder <= dividend;
          div_by_zero <= 1'b1;
          overflow <= 1'b0;
        end
`ifdef DIV_EARLY_ZERO_EN
        else if (dividend == '0) begin
          state <= DONE;
          done <= 1'b1;
          quotient <= '0;
          remainder <= '0;
          div_by_zero <= 1'b0;
          overflow <= 1'b0;
        end
`endif
        else begin
          state <= CALC;
          ready <= 1'b0;
        end
      end else begin
        case (state)
          CALC: begin
            pr <= trial[l_word] ? sh[l_word-1:0] : trial[l_word-1:0];
            dm <= {dm[l_word-2:0], ~trial[l_word]};
            cnt <= cnt - 6'd1;
            state <= cnt == 6'd1 ? FIX : CALC;
          end
          FIX: begin
            quotient <= q_neg ? -dm : dm;
            remainder <= r_neg ? -pr : pr;
            overflow <= ovf_p;
            div_by_zero <= 1'b0;
            done <= 1'b1;
            ready <= 1'b1;
            state <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_booth_seq_divider.sv
// tb_booth_seq_divider: scoreboard bench with directed signed divide vectors
module tb_booth_seq_divider;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic ready, done, div_by_zero, overflow;
  logic [3:0] quotient, remainder;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct {logic [3:0] q; logic [3:0] r; logic dz; logic ov; int lat; int issue;} exp_t;
  exp_t sb[$];

  booth_seq_divider #(.l_word(4)) dut (
    .clock(clock), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("latency", 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] q,
                       input logic [3:0] r, input logic dz, input logic ov, input int lat, input bit push);
    int n;
    n = 0;
    @(negedge clock);
    while (!ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    dividend = a;
    divisor = b;
    start = 1'b1;
    if (push) sb.push_back('{q, r, dz, ov, lat, cyc});
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_quotient"}, 32'(quotient), 0);
    chk({tag, "_remainder"}, 32'(remainder), 0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clock);
    chk_reset_outputs("rst");
    reset = 1'b0;
    issue(4'd7, 4'd2, 4'b0011, 4'b0001, 0, 0, 6, 1);
    chk("busy_c1", 32'(ready), 0);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clock);
      chk("busy_ready", 32'(ready), 0);
    end
    @(negedge clock);
    chk("done_ready", 32'(ready), 1);
    issue(4'b1001, 4'b0010, 4'b1101, 4'b1111, 0, 0, 6, 1);
    issue(4'd5, 4'd0, 4'b1111, 4'b0101, 1, 0, 1, 1);
    issue(4'd6, 4'd3, 4'b0010, 4'b0000, 0, 0, 6, 1);
    issue(4'd7, 4'd2, 4'b0000, 4'b0000, 0, 0, 0, 0);
    dividend = 4'd1;
    divisor = 4'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("abort_busy", 32'(ready), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset_outputs("abort");
    @(negedge clock);
    reset = 1'b0;
    issue(4'd7, 4'b1110, 4'b1101, 4'b0001, 0, 0, 6, 1);
    issue(4'b1010, 4'd4, 4'b1111, 4'b1110, 0, 0, 6, 1);
    issue(4'b1000, 4'b1111, 4'b1000, 4'b0000, 0, 1, 6, 1);
    issue(4'b1000, 4'b0011, 4'b1110, 4'b1110, 0, 0, 6, 1);
    issue(4'd3, 4'b1000, 4'b0000, 4'b0011, 0, 0, 6, 1);
    issue(4'b1111, 4'b1000, 4'b0000, 4'b1111, 0, 0, 6, 1);
`ifdef DIV_EARLY_ZERO_EN
    issue(4'd0, 4'd3, 4'b0000, 4'b0000, 0, 0, 1, 1);
`else
    issue(4'd0, 4'd3, 4'b0000, 4'b0000, 0, 0, 6, 1);
`endif
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
